// File: rtl/step_pkg.sv
// step_pkg: shared definitions for the step pulse generator.
//   state_t        debounce FSM state encoding
//   *_DEF          default timing constants for the 100 MHz board clock
package step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam int unsigned DB_CYCLES_DEF  = 2000000;   // 20 ms of stable level
    localparam int unsigned DB_W_DEF       = 21;
    localparam int unsigned RUN_PERIOD_DEF = 25000000;  // 4 Hz free-run rate
    localparam int unsigned RUN_W_DEF      = 25;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk  in   sampling clock
//   rst  in   synchronous, active-high reset (both flops cleared)
//   d    in   asynchronous input level
//   q    out  synchronised level, two clk cycles behind d
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns the raw push-button into a single-cycle step enable
// for the core, with manual single-step and free-run modes.
// Ports:
//   clk         in   board clock
//   rst         in   synchronous, active-high reset
//   button      in   raw asynchronous push-button level
//   run_mode    in   0 = one pulse per debounced press, 1 = periodic pulses
//   hold        in   1 = suppress all pulses (counters keep running)
//   step_pulse  out  one-cycle enable to the core
//   btn_level   out  debounced button level
//   step_count  out  pulses issued, modulo 2^16
//   run_active  out  synchronised run_mode
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned DB_W       = DB_W_DEF,
    parameter int unsigned RUN_PERIOD = RUN_PERIOD_DEF,
    parameter int unsigned RUN_W      = RUN_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic        run_mode,
    input  logic        hold,
    output logic        step_pulse,
    output logic        btn_level,
    output logic [15:0] step_count,
    output logic        run_active
);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_PERIOD - 1);

    logic b_s, r_s, h_s;

    sync2 u_sync_button (.clk(clk), .rst(rst), .d(button),   .q(b_s));
    sync2 u_sync_run    (.clk(clk), .rst(rst), .d(run_mode), .q(r_s));
    sync2 u_sync_hold   (.clk(clk), .rst(rst), .d(hold),     .q(h_s));

    assign run_active = r_s;

    // ---------------- debounce FSM ----------------
    state_t          state, state_next;
    logic [DB_W-1:0] db_cnt, db_cnt_next;
    logic            press_evt, press_evt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            db_cnt    <= '0;
            press_evt <= 1'b0;
        end else begin
            state     <= state_next;
            db_cnt    <= db_cnt_next;
            press_evt <= press_evt_next;
        end
    end

    always_comb begin
        state_next     = state;
        db_cnt_next    = db_cnt;
        press_evt_next = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (b_s) begin
                    state_next  = ST_PRESS_WAIT;
                    db_cnt_next = DB_W'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!b_s) begin
                    state_next  = ST_IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next     = ST_PRESSED;
                    db_cnt_next    = '0;
                    press_evt_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!b_s) begin
                    state_next  = ST_RELEASE_WAIT;
                    db_cnt_next = DB_W'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                // a short dip is treated as bounce: back to PRESSED, no new event
                if (b_s) begin
                    state_next  = ST_PRESSED;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = ST_IDLE;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                db_cnt_next = '0;
            end
        endcase
    end

    assign btn_level = (state == ST_PRESSED) || (state == ST_RELEASE_WAIT);

    // ---------------- pulse generation ----------------
    logic [RUN_W-1:0] run_cnt;
    logic             run_prev;
    logic             run_wrap;
    logic             run_chg;
    logic             pulse_next;

    assign run_wrap = r_s && (run_cnt == RUN_LAST);
    assign run_chg  = r_s ^ run_prev;

    always_comb begin
        pulse_next = 1'b0;
        if (!h_s && !run_chg) begin
            pulse_next = r_s ? run_wrap : press_evt;
        end
    end

    // run_cnt sits at zero whenever run mode is off, so entering run mode
    // always starts from a cleared count and the first wrap is RUN_PERIOD
    // cycles after run_active rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt    <= '0;
            run_prev   <= 1'b0;
            step_pulse <= 1'b0;
            step_count <= '0;
        end else begin
            run_prev   <= r_s;
            step_pulse <= pulse_next;
            if (!r_s || run_wrap) begin
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (pulse_next) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
module tb_step_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        button, run_mode, hold;
    logic        step_pulse, btn_level, run_active;
    logic [15:0] step_count;

    logic        w_run;
    logic        w_pulse, w_btn, w_active;
    logic [15:0] w_count;

    int unsigned cyc = 0;
    int unsigned vecs = 0;
    int unsigned errs = 0;
    int unsigned w_pulses = 0;
    logic [15:0] exp_count;

    typedef struct {
        int unsigned at;
        logic [15:0] cnt;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_pulse_gen #(.DB_CYCLES(4), .DB_W(3), .RUN_PERIOD(8), .RUN_W(4)) dut (
        .clk(clk), .rst(rst), .button(button), .run_mode(run_mode), .hold(hold),
        .step_pulse(step_pulse), .btn_level(btn_level),
        .step_count(step_count), .run_active(run_active)
    );

    // pulses every cycle in run mode, so the 16-bit counter wraps quickly
    step_pulse_gen #(.DB_CYCLES(4), .DB_W(3), .RUN_PERIOD(1), .RUN_W(1)) u_wrap (
        .clk(clk), .rst(rst), .button(1'b0), .run_mode(w_run), .hold(1'b0),
        .step_pulse(w_pulse), .btn_level(w_btn),
        .step_count(w_count), .run_active(w_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int unsigned at);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.at  = at;
        e.cnt = exp_count;
        sbq.push_back(e);
    endtask

    // scoreboard: every pulse must match the next expected entry
    always @(negedge clk) begin
        if (sbq.size() > 0 && cyc == sbq[0].at) begin
            chk("pulse_at", {31'd0, step_pulse}, 32'd1);
            chk("pulse_count", {16'd0, step_count}, {16'd0, sbq[0].cnt});
            void'(sbq.pop_front());
        end else if (step_pulse) begin
            chk("pulse_unexpected", {31'd0, step_pulse}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (w_pulse) begin
            w_pulses++;
            if (w_pulses == 65535)
                chk("wrap_ffff", {16'd0, w_count}, 32'h0000FFFF);
            else if (w_pulses == 65536)
                chk("wrap_zero", {16'd0, w_count}, 32'h00000000);
        end
    end

    initial begin
        int unsigned k, e;
        logic [15:0] base;

        rst = 1'b1; button = 1'b0; run_mode = 1'b0; hold = 1'b0; w_run = 1'b1;
        exp_count = 16'd0;
        repeat (2) tick();
        chk("rst_pulse",  {31'd0, step_pulse}, 32'd0);
        chk("rst_level",  {31'd0, btn_level},  32'd0);
        chk("rst_count",  {16'd0, step_count}, 32'd0);
        chk("rst_run",    {31'd0, run_active}, 32'd0);
        rst = 1'b0;
        tick();

        // clean press: pulse 7 edges after the drive point (6 after first sample)
        k = cyc;
        button = 1'b1;
        expect_pulse(k + 7);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5) chk("press_lvl_before", {31'd0, btn_level}, 32'd0);
            if (i == 6) chk("press_lvl_after",  {31'd0, btn_level}, 32'd1);
        end
        button = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) chk("release_lvl_before", {31'd0, btn_level}, 32'd1);
            if (i == 6) chk("release_lvl_after",  {31'd0, btn_level}, 32'd0);
        end
        chk("count_clean", {16'd0, step_count}, {16'd0, exp_count});

        // one cycle short of the debounce window: rejected
        button = 1'b1;
        repeat (3) tick();
        button = 1'b0;
        repeat (8) tick();
        chk("short_lvl",   {31'd0, btn_level},  32'd0);
        chk("short_count", {16'd0, step_count}, {16'd0, exp_count});

        // bounce then stable press
        for (int i = 0; i < 8; i++) begin
            button = (i % 2 == 0);
            tick();
            chk("bounce_lvl", {31'd0, btn_level}, 32'd0);
        end
        button = 1'b1;
        expect_pulse(cyc + 7);
        repeat (14) tick();
        // release bounce: two-cycle dip while PRESSED
        button = 1'b0;
        repeat (2) tick();
        button = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("relbounce_lvl", {31'd0, btn_level}, 32'd1);
        end
        button = 1'b0;
        repeat (8) tick();
        chk("bounce_lvl_end", {31'd0, btn_level},  32'd0);
        chk("bounce_count",   {16'd0, step_count}, {16'd0, exp_count});

        // run mode with a hold window
        run_mode = 1'b1;
        tick();
        chk("run_active_pre", {31'd0, run_active}, 32'd0);
        tick();
        chk("run_active_post", {31'd0, run_active}, 32'd1);
        e = cyc;
        base = exp_count;
        for (int j = 1; j <= 5; j++) expect_pulse(e + 8 * j);
        expect_pulse(e + 64);
        expect_pulse(e + 72);
        repeat (39) tick();
        chk("run_count_40", {16'd0, step_count}, {16'd0, base + 16'd4});
        repeat (2) tick();
        hold = 1'b1;
        repeat (19) tick();
        chk("hold_count", {16'd0, step_count}, {16'd0, base + 16'd5});
        tick();
        hold = 1'b0;
        repeat (13) tick();
        chk("resume_count", {16'd0, step_count}, {16'd0, base + 16'd7});
        run_mode = 1'b0;
        repeat (6) tick();
        chk("run_exit", {31'd0, run_active}, 32'd0);

        // counter wrap on the fast instance, bounded wait
        for (int i = 0; i < 70000 && w_pulses < 65536; i++) tick();
        chk("wrap_reached", {31'd0, (w_pulses >= 65536)}, 32'd1);
        chk("wrap_active",  {31'd0, w_active}, 32'd1);
        chk("wrap_btn",     {31'd0, w_btn},    32'd0);

        // reset while in PRESS_WAIT
        button = 1'b1;
        repeat (4) tick();
        chk("pw_lvl", {31'd0, btn_level}, 32'd0);
        rst = 1'b1;
        tick();
        exp_count = 16'd0;
        chk("midrst_pulse", {31'd0, step_pulse}, 32'd0);
        chk("midrst_level", {31'd0, btn_level},  32'd0);
        chk("midrst_count", {16'd0, step_count}, 32'd0);
        chk("midrst_run",   {31'd0, run_active}, 32'd0);
        rst = 1'b0;
        button = 1'b0;
        tick();
        chk("postrst_pulse", {31'd0, step_pulse}, 32'd0);
        repeat (10) tick();
        chk("postrst_count", {16'd0, step_count}, {16'd0, exp_count});
        chk("sb_drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
